pipe_stage_buf: RTL and testbench

//  Parametrised elastic pipeline register, the successor to the fixed fetch/decode/execute/memory latches.

---
 rtl/pipe_stage_buf_pkg.sv | 46 ++++
 rtl/pipe_stage_buf_mem.sv | 24 ++
 rtl/pipe_stage_buf.sv | 129 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline types: handshake pair, default depth and stage payload structs.
// Payload structs are carried through pipe_stage_buf opaquely via WIDTH = $bits(<struct>).
package pipe_stage_buf_pkg;

  localparam int PIPE_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic valid;
    logic ready;
  } pipe_hs_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
  } decode_data_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
  } execute_data_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        wb_en;
  } memory_data_t;

endpackage

// File: rtl/pipe_stage_buf_mem.sv
// Payload storage for pipe_stage_buf: DEPTH x WIDTH registers, one write port,
// one asynchronous read port. Contents are not reset; validity is tracked by the owner.
module pipe_buf_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline register holding up to DEPTH entries in FIFO order, with flush.
// Optional PIPE_STAGE_BUF_BYPASS_EN adds a zero-latency path from in_* to out_* when empty.
//
// state       | meaning
// OCC_EMPTY   | count == 0, out_valid low (unless bypassing)
// OCC_PARTIAL | 0 < count < DEPTH, accepts and presents
// OCC_FULL    | count == DEPTH, in_ready low
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = PIPE_DEPTH_DEFAULT,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [AW-1:0]    PTR_LAST = AW'(DEPTH - 1);

  occ_state_t       occ;
  pipe_hs_t         up_hs, dn_hs;
  logic [CNT_W-1:0] count_r, count_nxt;
  logic [AW-1:0]    wr_ptr, wr_nxt, rd_ptr, rd_nxt;
  logic [WIDTH-1:0] rdata;
  logic             byp, enq, deq, store, pop;

  // Explicit wrap so non-power-of-2 depths never index past the array.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef PIPE_STAGE_BUF_BYPASS_EN
  assign byp = (count_r == '0) && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  assign in_ready = (count_r != FULL_CNT);
  assign up_hs    = '{valid: in_valid, ready: in_ready};
  assign dn_hs    = '{valid: out_valid, ready: out_ready};
  assign enq      = up_hs.valid & up_hs.ready;
  assign deq      = dn_hs.valid & dn_hs.ready;
  // A bypassed item consumed downstream the same cycle never touches storage.
  assign store    = enq && !(byp && out_ready);
  assign pop      = deq && (count_r != '0);
  assign count    = count_r;

  always_comb begin
    out_valid = (count_r != '0);
    out_data  = out_valid ? rdata : '0;
    if (byp) begin
      out_valid = 1'b1;
      out_data  = in_data;
    end
  end

  always_comb begin
    occ = OCC_PARTIAL;
    if (count_r == '0)           occ = OCC_EMPTY;
    else if (count_r == FULL_CNT) occ = OCC_FULL;
  end

  always_comb begin
    count_nxt = count_r;
    wr_nxt    = wr_ptr;
    rd_nxt    = rd_ptr;
    if (flush) begin
      count_nxt = '0;
      wr_nxt    = '0;
      rd_nxt    = '0;
    end else begin
      if (store) wr_nxt = ptr_inc(wr_ptr);
      if (pop)   rd_nxt = ptr_inc(rd_ptr);
      case (occ)
        OCC_EMPTY:   if (store) count_nxt = ONE_CNT;
        OCC_PARTIAL: begin
          if (store && !pop)      count_nxt = count_r + ONE_CNT;
          else if (pop && !store) count_nxt = count_r - ONE_CNT;
        end
        OCC_FULL:    if (pop) count_nxt = FULL_CNT - ONE_CNT;
        default:     count_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      count_r <= count_nxt;
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
    end
  end

  pipe_buf_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (store && !flush),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

`ifndef SYNTHESIS
  a_cnt_bound: assert property (@(posedge clk) disable iff (reset) count_r <= FULL_CNT);
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    (count_r == '0 && !byp) |-> !out_valid);
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (DEPTH=2 and DEPTH=3 instances).
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        f2, v2, r2, ir2, ov2;
  logic [31:0] d2, od2;
  logic [1:0]  c2;
  logic        f3, v3, r3, ir3, ov3;
  logic [31:0] d3, od3;
  logic [1:0]  c3;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(32), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .flush(f2), .in_valid(v2), .in_ready(ir2), .in_data(d2),
    .out_valid(ov2), .out_ready(r2), .out_data(od2), .count(c2)
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .flush(f3), .in_valid(v3), .in_ready(ir3), .in_data(d3),
    .out_valid(ov3), .out_ready(r3), .out_data(od3), .count(c3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (c2 !== 2'd0) $display("FAIL rst_count: got %0d expected 0", c2); else n_pass++;
    n_checks++; if (ov2 !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", ov2); else n_pass++;
    n_checks++; if (ir2 !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", ir2); else n_pass++;
    reset = 1'b0;
    tick();
    r2 = 1'b0; v2 = 1'b1; d2 = 32'h11;
    tick();
    d2 = 32'h22;
    tick();
    v2 = 1'b0;
    @(negedge clk);
    n_checks++; if (c2 !== 2'd2) $display("FAIL pre_rst_count: got %0d expected 2", c2); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++; if (c2 !== 2'd0) $display("FAIL mid_rst_count: got %0d expected 0", c2); else n_pass++;
    n_checks++; if (ov2 !== 1'b0) $display("FAIL mid_rst_out_valid: got %b expected 0", ov2); else n_pass++;
    n_checks++; if (od2 !== 32'h0) $display("FAIL mid_rst_out_data: got %0h expected 0", od2); else n_pass++;
    n_checks++; if (ir2 !== 1'b1) $display("FAIL mid_rst_in_ready: got %b expected 1", ir2); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_checks++; if (ov2 !== 1'b0) $display("FAIL post_rst_out_valid: got %b expected 0", ov2); else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_v;
    int got;
    exp_v = 32'h1;
    got = 0;
    r2 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      v2 = 1'b1;
      d2 = 32'(i);
      @(negedge clk);
`ifndef PIPE_STAGE_BUF_BYPASS_EN
      if (i == 1) begin
        n_checks++; if (ov2 !== 1'b0) $display("FAIL stream_lag: got out_valid %b expected 0", ov2); else n_pass++;
      end
`endif
      if (ov2) begin
        n_checks++; if (od2 !== exp_v) $display("FAIL stream_data: got %0h expected %0h", od2, exp_v); else n_pass++;
        exp_v++;
        got++;
      end
      tick();
    end
    v2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ov2) begin
        n_checks++; if (od2 !== exp_v) $display("FAIL stream_data: got %0h expected %0h", od2, exp_v); else n_pass++;
        exp_v++;
        got++;
      end
      tick();
    end
    n_checks++; if (got !== 8) $display("FAIL stream_items: got %0d expected 8", got); else n_pass++;
    n_checks++; if (c2 !== 2'd0) $display("FAIL stream_drained: got %0d expected 0", c2); else n_pass++;
  endtask

  task automatic test_backpressure();
    int k;
    logic acc;
    r2 = 1'b0; v2 = 1'b1; d2 = 32'hA;
    tick();
    d2 = 32'hB;
    tick();
    d2 = 32'hC;
    @(negedge clk);
    n_checks++; if (c2 !== 2'd2) $display("FAIL bp_full_count: got %0d expected 2", c2); else n_pass++;
    n_checks++; if (ir2 !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", ir2); else n_pass++;
    n_checks++; if (od2 !== 32'hA) $display("FAIL bp_head: got %0h expected a", od2); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (c2 !== 2'd2) $display("FAIL bp_hold_count: got %0d expected 2", c2); else n_pass++;
    n_checks++; if (od2 !== 32'hA) $display("FAIL bp_hold_head: got %0h expected a", od2); else n_pass++;
    tick();
    r2 = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc = v2 & ir2;
      if (ov2) begin
        n_checks++; if (od2 !== 32'hA + 32'(k)) $display("FAIL bp_order: got %0h expected %0h", od2, 32'hA + 32'(k)); else n_pass++;
        k++;
      end
      tick();
      if (acc) v2 = 1'b0;
    end
    n_checks++; if (k !== 3) $display("FAIL bp_items: got %0d expected 3", k); else n_pass++;
    n_checks++; if (c2 !== 2'd0) $display("FAIL bp_drained: got %0d expected 0", c2); else n_pass++;
  endtask

  task automatic test_flush();
    r2 = 1'b0; v2 = 1'b1; d2 = 32'h1;
    tick();
    d2 = 32'h2;
    tick();
    @(negedge clk);
    n_checks++; if (c2 !== 2'd2) $display("FAIL flush_pre_count: got %0d expected 2", c2); else n_pass++;
    f2 = 1'b1; d2 = 32'hF; r2 = 1'b1;
    tick();
    f2 = 1'b0; v2 = 1'b0;
    @(negedge clk);
    n_checks++; if (c2 !== 2'd0) $display("FAIL flush_count: got %0d expected 0", c2); else n_pass++;
    n_checks++; if (ov2 !== 1'b0) $display("FAIL flush_out_valid: got %b expected 0", ov2); else n_pass++;
    n_checks++; if (ir2 !== 1'b1) $display("FAIL flush_in_ready: got %b expected 1", ir2); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      n_checks++; if (ov2 !== 1'b0 || od2 !== 32'h0) $display("FAIL flush_ghost: got valid %b data %0h expected 0 0", ov2, od2); else n_pass++;
    end
    tick();
    r2 = 1'b0; v2 = 1'b1; d2 = 32'hE;
    tick();
    d2 = 32'h7;
    @(negedge clk);
    n_checks++; if (c2 !== 2'd1) $display("FAIL flush_partial_pre: got %0d expected 1", c2); else n_pass++;
    f2 = 1'b1;
    tick();
    f2 = 1'b0; v2 = 1'b0;
    @(negedge clk);
    n_checks++; if (c2 !== 2'd0) $display("FAIL flush_partial_count: got %0d expected 0", c2); else n_pass++;
    tick();
  endtask

  task automatic test_wrap();
    for (int v = 0; v < 10; v++) begin
      v3 = 1'b1; d3 = 32'(v); r3 = 1'b0;
      tick();
      v3 = 1'b0; r3 = 1'b1;
      @(negedge clk);
      n_checks++; if (ov3 !== 1'b1 || od3 !== 32'(v)) $display("FAIL wrap_data: got valid %b data %0h expected 1 %0h", ov3, od3, v); else n_pass++;
      n_checks++; if (c3 !== 2'd1) $display("FAIL wrap_count: got %0d expected 1", c3); else n_pass++;
      tick();
    end
    r3 = 1'b0; v3 = 1'b1;
    for (int v = 0; v < 3; v++) begin
      d3 = 32'h20 + 32'(v);
      tick();
    end
    v3 = 1'b0;
    @(negedge clk);
    n_checks++; if (c3 !== 2'd3 || ir3 !== 1'b0) $display("FAIL wrap_full: got count %0d ready %b expected 3 0", c3, ir3); else n_pass++;
    tick();
    r3 = 1'b1;
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      n_checks++; if (od3 !== 32'h20 + 32'(v)) $display("FAIL wrap_drain: got %0h expected %0h", od3, 32'h20 + 32'(v)); else n_pass++;
      tick();
    end
    @(negedge clk);
    n_checks++; if (c3 !== 2'd0 || ov3 !== 1'b0) $display("FAIL wrap_empty: got count %0d valid %b expected 0 0", c3, ov3); else n_pass++;
    tick();
  endtask

  task automatic test_bypass();
    r2 = 1'b1; v2 = 1'b1; d2 = 32'h55;
    @(negedge clk);
`ifdef PIPE_STAGE_BUF_BYPASS_EN
    n_checks++; if (ov2 !== 1'b1 || od2 !== 32'h55) $display("FAIL byp_same_cycle: got valid %b data %0h expected 1 55", ov2, od2); else n_pass++;
    tick();
    v2 = 1'b0;
    @(negedge clk);
    n_checks++; if (c2 !== 2'd0) $display("FAIL byp_count: got %0d expected 0", c2); else n_pass++;
`else
    n_checks++; if (ov2 !== 1'b0 || od2 !== 32'h0) $display("FAIL nobyp_same_cycle: got valid %b data %0h expected 0 0", ov2, od2); else n_pass++;
    tick();
    v2 = 1'b0;
    @(negedge clk);
    n_checks++; if (c2 !== 2'd1 || od2 !== 32'h55) $display("FAIL nobyp_next: got count %0d data %0h expected 1 55", c2, od2); else n_pass++;
`endif
    tick();
  endtask

  initial begin
    reset = 1'b1;
    f2 = 1'b0; v2 = 1'b0; r2 = 1'b0; d2 = '0;
    f3 = 1'b0; v3 = 1'b0; r3 = 1'b0; d3 = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap();
    test_bypass();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
